temp_display_driver: RTL and testbench



---
 rtl/temp_display_pkg.sv | 33 +++
 rtl/temp_bcd_converter.sv | 59 +++++
 rtl/temp_display_driver.sv | 62 ++++++
 tb/tb_temp_display_driver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/temp_display_pkg.sv
// temp_display_pkg: shared widths, seven-segment patterns and converter state type
package temp_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W = 16;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef enum logic {IDLE, SHIFT} conv_state_t;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/temp_bcd_converter.sv
// temp_bcd_converter: sequential 16-cycle double-dabble binary-to-BCD engine with pending reload
module temp_bcd_converter
  import temp_display_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [15:0]      value_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [BCD_W-1:0] bcd
);
  conv_state_t state, state_n;
  logic [3:0] cnt;
  logic [15:0] bin, pend_val;
  logic [BCD_W+3:0] acc, adj, acc_n;
  logic pending;
  always_comb begin
    adj = acc;
    for (int i = 0; i <= NUM_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    acc_n = {adj[BCD_W+2:0], bin[15]};
    state_n = state == IDLE ? ((load || pending) ? SHIFT : IDLE) : (cnt == 4'd15 ? IDLE : SHIFT);
  end
  assign busy = state == SHIFT;
  assign done = busy && cnt == 4'd15;
  assign bcd = acc_n[BCD_W-1:0];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bin <= '0;
      acc <= '0;
      pend_val <= '0;
      pending <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (load || pending) begin
          bin <= load ? value_in : pend_val;
          acc <= '0;
          cnt <= '0;
          pending <= 1'b0;
        end
      end else begin
        acc <= acc_n;
        bin <= {bin[14:0], 1'b0};
        cnt <= cnt + 4'd1;
        if (load) begin
          pending <= 1'b1;
          pend_val <= value_in;
        end
        if (done) overflow <= |acc_n[BCD_W+3:BCD_W];
      end
    end
  end
endmodule

// File: rtl/temp_display_driver.sv
// temp_display_driver: BCD conversion plus multiplexed 4-digit seven-segment scanning with blanking
module temp_display_driver
  import temp_display_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int DP_POS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  digit_select
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic [BCD_W-1:0] disp, bcd;
  logic done, blank;
  logic [NUM_DIGITS-1:0] lead;
  logic [3:0] nib;
  logic [6:0] seg_n;
  temp_bcd_converter u_conv (
    .clock(clock),
    .reset(reset),
    .load(load),
    .value_in(value_in),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .bcd(bcd)
  );
  always_comb begin
    lead = '0;
    lead[NUM_DIGITS-1] = disp[BCD_W-1 -: 4] == 4'd0;
    for (int i = NUM_DIGITS-2; i >= 0; i--)
      lead[i] = lead[i+1] && disp[4*i +: 4] == 4'd0;
    nib = disp[{idx, 2'b00} +: 4];
    blank = lead[idx] && int'(idx) > DP_POS;
    seg_n = overflow ? SEG_DASH : blank ? SEG_BLANK : seg_of(nib);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      disp <= '0;
      presc <= '0;
      idx <= '0;
      segments <= '0;
      dp <= 1'b0;
      digit_select <= '0;
    end else begin
      if (done) disp <= bcd;
      presc <= presc == PW'(SCAN_DIV-1) ? '0 : presc + PW'(1);
      idx <= presc == PW'(SCAN_DIV-1) ? idx + 2'd1 : idx;
      segments <= seg_n;
      dp <= int'(idx) == DP_POS && !overflow;
      digit_select <= 4'b0001 << idx;
    end
  end
endmodule

// File: tb/tb_temp_display_driver.sv
// tb_temp_display_driver: directed self-checking bench for temp_display_driver
module tb_temp_display_driver;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [15:0] value_in = '0;
  logic busy, overflow, dp;
  logic [6:0] segments;
  logic [3:0] digit_select;
  int checks = 0;
  int failures = 0;
  temp_display_driver #(.SCAN_DIV(4), .DP_POS(1)) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .value_in(value_in),
    .busy(busy),
    .overflow(overflow),
    .segments(segments),
    .dp(dp),
    .digit_select(digit_select)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_load(input logic [15:0] v);
    @(negedge clock);
    load = 1'b1;
    value_in = v;
    @(negedge clock);
    load = 1'b0;
  endtask
  task automatic run_load(input string tag, input logic [15:0] v);
    int n;
    n = 0;
    do_load(v);
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    check({tag, " busy_len"}, n, 16);
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    check({tag, " idle"}, {31'd0, busy}, 0);
  endtask
  task automatic check_display(input string tag, input logic [27:0] segs, input logic ov);
    for (int c = 0; c < 16; c++) begin
      int k;
      k = 0;
      @(negedge clock);
      for (int i = 0; i < 4; i++) if (digit_select[i]) k = i;
      check({tag, " onehot"}, {31'd0, $onehot(digit_select)}, 1);
      check({tag, " seg"}, {25'd0, segments}, {25'd0, segs[k*7 +: 7]});
      check({tag, " dp"}, {31'd0, dp}, {31'd0, (k == 1 && !ov)});
      check({tag, " ovf"}, {31'd0, overflow}, {31'd0, ov});
    end
  endtask
  initial begin
    int n;
    logic [3:0] e;
    repeat (3) @(negedge clock);
    check("rst busy", {31'd0, busy}, 0);
    check("rst ovf", {31'd0, overflow}, 0);
    check("rst seg", {25'd0, segments}, 0);
    check("rst dp", {31'd0, dp}, 0);
    check("rst sel", {28'd0, digit_select}, 0);
    reset = 1'b0;
    for (int s = 0; s < 16; s++) begin
      @(negedge clock);
      e = 4'b0001 << (s / 4);
      check("scan seq", {28'd0, digit_select}, {28'd0, e});
    end
    check_display("zero_rst", {7'h00, 7'h00, 7'h3F, 7'h3F}, 1'b0);
    run_load("215", 16'd215);
    check_display("215", {7'h00, 7'h5B, 7'h06, 7'h6D}, 1'b0);
    run_load("5", 16'd5);
    check_display("5", {7'h00, 7'h00, 7'h3F, 7'h6D}, 1'b0);
    run_load("0", 16'd0);
    check_display("0", {7'h00, 7'h00, 7'h3F, 7'h3F}, 1'b0);
    run_load("9999", 16'd9999);
    check_display("9999", {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 1'b0);
    run_load("10000", 16'd10000);
    check_display("10000", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);
    run_load("65535", 16'd65535);
    check_display("65535", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);
    do_load(16'd123);
    repeat (4) @(negedge clock);
    do_load(16'd456);
    repeat (3) @(negedge clock);
    do_load(16'd789);
    wait_idle("123");
    n = 0;
    while (!busy && n < 5) begin
      n++;
      @(negedge clock);
    end
    check("pend gap", n, 1);
    check_display("123", {7'h00, 7'h06, 7'h5B, 7'h4F}, 1'b0);
    wait_idle("789");
    check_display("789", {7'h00, 7'h07, 7'h7F, 7'h6F}, 1'b0);
    do_load(16'd4321);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid busy", {31'd0, busy}, 0);
    check("mid ovf", {31'd0, overflow}, 0);
    check("mid seg", {25'd0, segments}, 0);
    check("mid dp", {31'd0, dp}, 0);
    check("mid sel", {28'd0, digit_select}, 0);
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (busy) n++;
    end
    check("no resume", n, 0);
    check_display("after_rst", {7'h00, 7'h00, 7'h3F, 7'h3F}, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
